// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and 7-segment constants for the calculator display
package calc_pkg;

  typedef enum logic {
    OCIOSO   = 1'b0,
    CONVERTE = 1'b1
  } estado_t;

  localparam logic [2:0] ULTIMA_ITER = 3'd7;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/bcd_7seg.sv
// rtl/bcd_7seg.sv - BCD digit to active-low 7-segment decoder with blanking
module bcd_7seg
  import calc_pkg::*;
(
  input  logic [3:0] digito,
  input  logic       apaga,
  output logic [6:0] segmentos
);

  always_comb begin
    segmentos = SEG_APAGADO;
    if (!apaga) begin
      case (digito)
        4'd0:    segmentos = SEG_0;
        4'd1:    segmentos = SEG_1;
        4'd2:    segmentos = SEG_2;
        4'd3:    segmentos = SEG_3;
        4'd4:    segmentos = SEG_4;
        4'd5:    segmentos = SEG_5;
        4'd6:    segmentos = SEG_6;
        4'd7:    segmentos = SEG_7;
        4'd8:    segmentos = SEG_8;
        4'd9:    segmentos = SEG_9;
        default: segmentos = SEG_APAGADO;
      endcase
    end
  end

endmodule

// File: rtl/exibe_resultado.sv
// rtl/exibe_resultado.sv - sequential double-dabble conversion and 3-digit multiplexed display
module exibe_resultado
  import calc_pkg::*;
#(
  parameter int DIV_VARRE = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] valor,
  input  logic       iniciar,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] anodos,
  output logic [6:0] segmentos
);

  localparam int PW = $clog2(DIV_VARRE);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_VARRE - 1);

  estado_t       r_estado;
  logic [7:0]    r_shift;
  logic [11:0]   r_bcd;
  logic [2:0]    r_iter;
  logic [3:0]    r_centenas;
  logic [3:0]    r_dezenas;
  logic [3:0]    r_unidades;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;

  logic [19:0]   w_desloc;
  logic [3:0]    w_digito;
  logic          w_apaga;

  function automatic logic [3:0] ajusta(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Hundreds never exceeds 2 for an 8-bit input, so its top bit is shifted out.
  assign w_desloc = {3'(ajusta(r_bcd[11:8])), ajusta(r_bcd[7:4]), ajusta(r_bcd[3:0]),
                     r_shift, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= OCIOSO;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_centenas <= '0;
      r_dezenas  <= '0;
      r_unidades <= '0;
      ocupado    <= 1'b0;
      pronto     <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (iniciar) begin
            r_shift  <= valor;
            r_bcd    <= '0;
            r_iter   <= '0;
            ocupado  <= 1'b1;
            r_estado <= CONVERTE;
          end
        end
        CONVERTE: begin
          r_bcd   <= w_desloc[19:8];
          r_shift <= w_desloc[7:0];
          r_iter  <= r_iter + 3'd1;
          if (r_iter == ULTIMA_ITER) begin
            r_centenas <= w_desloc[19:16];
            r_dezenas  <= w_desloc[15:12];
            r_unidades <= w_desloc[11:8];
            pronto     <= 1'b1;
            ocupado    <= 1'b0;
            r_estado   <= OCIOSO;
          end
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_idx   <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Blanked digits keep their scan slot; only the segments go dark.
  always_comb begin
    w_digito = r_unidades;
    w_apaga  = 1'b0;
    anodos   = 3'b110;
    case (r_idx)
      2'd1: begin
        w_digito = r_dezenas;
        w_apaga  = (r_centenas == 4'd0) && (r_dezenas == 4'd0);
        anodos   = 3'b101;
      end
      2'd2: begin
        w_digito = r_centenas;
        w_apaga  = (r_centenas == 4'd0);
        anodos   = 3'b011;
      end
      default: begin
        w_digito = r_unidades;
        w_apaga  = 1'b0;
        anodos   = 3'b110;
      end
    endcase
  end

  bcd_7seg u_bcd_7seg (
    .digito    (w_digito),
    .apaga     (w_apaga),
    .segmentos (segmentos)
  );

endmodule

// File: tb/tb_exibe_resultado.sv
// tb/tb_exibe_resultado.sv - scoreboard bench for exibe_resultado
module tb_exibe_resultado;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] valor;
  logic       iniciar;
  logic       ocupado;
  logic       pronto;
  logic [2:0] anodos;
  logic [6:0] segmentos;

  exibe_resultado #(.DIV_VARRE(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valor     (valor),
    .iniciar   (iniciar),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .anodos    (anodos),
    .segmentos (segmentos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v;
    int due;
  } exp_t;

  exp_t q[$];
  int   m_cyc;
  int   m_tick;
  int   m_cnt;
  int   m_shown;
  int   n_chk;
  int   n_ok;

  task automatic verifica(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_cyc);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    if (idx == 0) return seg_of(u);
    if (idx == 1) return (h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
    return (h == 0) ? 7'b1111111 : seg_of(h);
  endfunction

  // Reference: acceptance only when not busy, busy for 8 edges after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      m_tick <= 0;
      m_cnt  <= 0;
      q.delete();
    end else begin
      m_cyc  <= m_cyc + 1;
      m_tick <= m_tick + 1;
      if (m_cnt == 0 && iniciar) begin
        q.push_back('{int'(valor), m_cyc + 9});
        m_cnt <= 8;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    int   idx;
    logic exp_p;
    #2;
    if (!rst_n) m_shown = 0;
    if (q.size() > 0 && q[0].due < m_cyc) void'(q.pop_front());
    exp_p = (q.size() > 0) && (q[0].due == m_cyc);
    verifica("pronto", int'(pronto), int'(exp_p));
    if (exp_p) begin
      m_shown = q[0].v;
      void'(q.pop_front());
    end
    verifica("ocupado", int'(ocupado), int'(m_cnt != 0));
    idx = (m_tick / DIV) % 3;
    verifica("anodos", int'(anodos), int'(~(3'b001 << idx) & 3'b111));
    verifica("segmentos", int'(segmentos), int'(exp_seg(m_shown, idx)));
  end

  task automatic espera(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic converte(input int v);
    @(negedge clk);
    valor   = 8'(v);
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    valor   = 8'($urandom_range(0, 255));
    espera(14);
  endtask

  initial begin
    n_chk   = 0;
    n_ok    = 0;
    m_shown = 0;
    rst_n   = 1'b0;
    iniciar = 1'b0;
    valor   = 8'd0;
    espera(3);
    rst_n = 1'b1;
    espera(4);

    converte(255);
    converte(0);
    converte(7);
    converte(105);
    converte(99);
    converte(100);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      iniciar = 1'b1;
      valor   = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    iniciar = 1'b0;
    espera(14);

    @(negedge clk);
    valor   = 8'd200;
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    espera(3);
    rst_n = 1'b0;
    espera(2);
    rst_n = 1'b1;
    espera(14);

    for (int i = 0; i < 4; i++) converte(int'($urandom_range(0, 255)));

    verifica("fila_vazia", q.size(), 0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
